// File: rtl/spine_link_merge_pkg.sv
// Shared definitions for the spine link merge block: flit geometry, port count
// and the destination-field helper used wherever a flit's target is needed.
package spine_link_merge_pkg;

    localparam int FLIT_W      = 16;
    localparam int DEST_W      = 6;
    localparam int DEST_MSB    = FLIT_W - 1;
    localparam int DEST_LSB    = FLIT_W - DEST_W;
    localparam int SPINE_PORTS = 4;

    function automatic logic [DEST_W-1:0] flitDest(input logic [FLIT_W-1:0] flit);
        return flit[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/spine_sync_fifo.sv
// Small synchronous FIFO for one spine source. A push into a full FIFO is
// ignored even when a pop happens in the same cycle; the caller counts it as a drop.
module spine_sync_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              pop_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              pushOk, popOk;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rdPtr_q];

    assign pushOk = push_i && !full_o;
    assign popOk  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
            if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/spine_link_merge.sv
// Merges up to NUM_IN ready-less spine sources through per-source FIFOs onto
// one registered round-robin output; flits arriving at a full FIFO are dropped and counted.
module spine_link_merge
    import spine_link_merge_pkg::*;
#(
    parameter int DWIDTH     = FLIT_W,
    parameter int NUM_IN     = SPINE_PORTS,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [NUM_IN*DWIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    output logic [DEST_W-1:0]        out_dest_addr,
    input  logic                     out_ready,
    output logic [NUM_IN-1:0]        fifo_full,
    output logic [NUM_IN-1:0]        fifo_empty,
    output logic [CNT_W-1:0]         drop_count,
    output logic [IDX_W-1:0]         grant_idx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DWIDTH-1:0] headData  [NUM_IN];
    logic [CW-1:0]     fifoCount [NUM_IN];
    logic [NUM_IN-1:0] fifoFull, fifoEmpty, popVec, dropVec;

    logic [DWIDTH-1:0] outData_q;
    logic              outValid_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  rrPtr_q;
    logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

    logic              canLoad, found;
    logic [IDX_W-1:0]  pick, pickNext;
    int                scanIdx;

    for (genvar g = 0; g < NUM_IN; g++) begin : gSrc
        spine_sync_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) uFifo (
            .clk     (ACLK),
            .rst_n   (ARESETn),
            .push_i  (in_valid[g]),
            .data_i  (in_data[g*DWIDTH +: DWIDTH]),
            .pop_i   (popVec[g]),
            .data_o  (headData[g]),
            .full_o  (fifoFull[g]),
            .empty_o (fifoEmpty[g]),
            .count_o (fifoCount[g])
        );

        // Fullness is judged on the count before this cycle's pop.
        assign dropVec[g] = in_valid[g] && (fifoCount[g] == CW'(FIFO_DEPTH));
    end

    assign canLoad = !outValid_q || out_ready;

    always_comb begin
        found   = 1'b0;
        pick    = '0;
        scanIdx = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            scanIdx = int'(rrPtr_q) + k;
            if (scanIdx >= NUM_IN) scanIdx = scanIdx - NUM_IN;
            if (!found && !fifoEmpty[scanIdx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = IDX_W'(scanIdx);
            end
        end
    end

    assign pickNext = (pick == IDX_W'(NUM_IN - 1)) ? '0 : pick + IDX_W'(1);

    always_comb begin
        popVec = '0;
        if (canLoad && found) popVec[pick] = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            outData_q  <= '0;
            outValid_q <= 1'b0;
            grant_q    <= '0;
            rrPtr_q    <= '0;
        end else if (canLoad) begin
            if (found) begin
                outData_q  <= headData[pick];
                outValid_q <= 1'b1;
                grant_q    <= pick;
                rrPtr_q    <= pickNext;
            end else begin
                outValid_q <= 1'b0;
            end
        end
    end

    // Several sources may drop together; each one bumps the count, clamped at all ones.
    always_comb begin
        dropCnt_d = dropCnt_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (dropVec[i] && (dropCnt_d != '1)) dropCnt_d = dropCnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) dropCnt_q <= '0;
        else          dropCnt_q <= dropCnt_d;
    end

    if (DWIDTH == FLIT_W) begin : gDestFn
        assign out_dest_addr = flitDest(outData_q);
    end else begin : gDestSlice
        assign out_dest_addr = outData_q[DWIDTH-1 -: DEST_W];
    end

    assign out_data   = outData_q;
    assign out_valid  = outValid_q;
    assign grant_idx  = grant_q;
    assign fifo_full  = fifoFull;
    assign fifo_empty = fifoEmpty;
    assign drop_count = dropCnt_q;

endmodule

// File: doc/spine_link_merge.md
Name: spine_link_merge

Overview:
- Spine-side counterpart of a group tile's four spine ports.
- Collects flits that tile routers emit on their `spineN_out_data`/`spineN_out_valid` ports, with up to NUM_IN sources.
- Buffers each source in its own FIFO and merges the sources round-robin onto one registered output. That output drives a remote router's `spineN_in_data`, `spineN_in_valid` and `spineN_dest_addr`.
- The upstream router port has no ready signal. Overflow therefore drops the flit and counts it.

Parameters:
- DWIDTH, 16, flit width; destination field is bits [DWIDTH-1:DWIDTH-6].
- NUM_IN, 4, number of upstream spine sources.
- FIFO_DEPTH, 4, entries per input FIFO (power of two, at least 2).
- CNT_W, 16, width of the drop counter.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*DWIDTH  packed source flits; source i occupies [i*DWIDTH +: DWIDTH].
- in_valid  in  NUM_IN  per-source valid (no ready returned).
- out_data  out  DWIDTH  merged flit to the remote spine input.
- out_valid  out  1  out_data is valid.
- out_dest_addr  out  6  equals out_data[DWIDTH-1:DWIDTH-6].
- out_ready  in  1  downstream accept; tied 1 when driving a router spine input.
- fifo_full  out  NUM_IN  per-source FIFO full.
- fifo_empty  out  NUM_IN  per-source FIFO empty.
- drop_count  out  CNT_W  saturating count of dropped flits.
- grant_idx  out  log2(NUM_IN)  source index of the flit currently on out_data.

Behaviour:
- Reset values (asynchronous, applied whenever ARESETn is low, including mid-transfer):
  - out_data=0, out_valid=0, out_dest_addr=0, grant_idx=0.
  - fifo_full=0, fifo_empty=all 1s, drop_count=0.
  - All FIFO pointers and counts cleared; rr_ptr=0. In-flight flits are discarded.
- Write side, per source i, each cycle:
  - If in_valid[i] and the FIFO count before this cycle's pop is < FIFO_DEPTH, push in_data slice i.
  - Otherwise, if in_valid[i], drop the flit.
  - A push to a full FIFO in the same cycle as a pop from it is still dropped. Full is evaluated on the pre-pop count.
- Drop counter:
  - drop_count increases by the number of sources dropping in that cycle (0..NUM_IN).
  - It saturates at all 1s and never wraps.
- Output stage is one register. It can load when out_valid==0 or out_ready==1.
- Arbitration, when the output stage can load:
  - Scan sources starting at rr_ptr, wrapping modulo NUM_IN. The first source with a non-empty FIFO is granted.
  - Pop its head into out_data and set out_valid=1, grant_idx=granted index, rr_ptr=(granted+1) mod NUM_IN.
  - If no FIFO is non-empty, set out_valid=0, leave out_data at its last value, and leave rr_ptr unchanged.
- Hold: while out_valid=1 and out_ready=0, out_data, out_dest_addr and grant_idx are held, and nothing is popped.
- No bypass: a flit pushed at edge k is eligible at edge k+1. Minimum latency is 2 cycles from the in_valid sample to out_valid.
- Throughput: one flit per cycle when out_ready=1. Under saturation, each source receives every NUM_IN-th slot.
- fifo_full and fifo_empty are registered from the updated counts and valid in the same cycle as those counts.

Decomposition:
- Shared package holds:
  - `FLIT_W`=16, `DEST_W`=6, `DEST_MSB`/`DEST_LSB` field positions.
  - `SPINE_PORTS`=4.
  - A function extracting the destination address from a flit.
- One sub-module, `spine_sync_fifo`: DWIDTH x FIFO_DEPTH synchronous FIFO with push, pop, full, empty and count outputs. It is instantiated NUM_IN times.
- Round-robin arbitration and drop counting stay in the top module.

Test Plan:
- Reset, then a single flit: in_valid[2]=1 with in_data slice 2 = 16'hA5C3 for one cycle. Expect out_valid=1 two cycles later with out_data=A5C3, out_dest_addr=6'h29, grant_idx=2. Expect out_valid=0 on the following cycle.
- All four sources push together with flits 16'h0401, 16'h0802, 16'h0C03, 16'h1004, out_ready=1. Expect outputs in order src0, src1, src2, src3 on consecutive cycles, with drop_count=0.
- Overflow: out_ready=0 and source 1 pushes 6 consecutive flits. Expect fifo_full[1]=1 after 5 pushes: the 4 FIFO entries plus 1 in the output register. Expect drop_count=1.
- Backpressure hold: out_valid=1 with out_data=16'h1234 and out_ready=0 for 3 cycles. Expect out_data to stay stable and FIFO counts unchanged. When out_ready=1, expect the next flit on the following cycle.
- Drop counter saturation with CNT_W=4: force 20 drops. Expect drop_count=4'hF and no wrap.
- Reset mid-burst: assert ARESETn=0 while 3 FIFOs are non-empty. Expect immediate out_valid=0, fifo_empty=4'hF and drop_count=0. After release, the first grant comes from source 0's new traffic.
